// File: rtl/output_stream_scheduler_if.sv
// Signal bundle between two word requesters, the scheduler and its AXI4-Stream sink.
// The master modport is the scheduler's view; the slave modport is the environment's view.
interface output_stream_scheduler_if #(
  parameter int AXI_WIDTH    = 8,
  parameter int BUFFER_WIDTH = 35
);
  logic [BUFFER_WIDTH-1:0] req0_data;
  logic [BUFFER_WIDTH-1:0] req1_data;
  logic                    req0_valid;
  logic                    req1_valid;
  logic                    req0_ready;
  logic                    req1_ready;
  logic [AXI_WIDTH-1:0]    m_tdata;
  logic                    m_tvalid;
  logic                    m_tready;
  logic                    m_tlast;
  logic                    m_tid;
  logic                    busy;

  modport master (
    input  req0_data, req1_data, req0_valid, req1_valid, m_tready,
    output req0_ready, req1_ready, m_tdata, m_tvalid, m_tlast, m_tid, busy
  );

  modport slave (
    output req0_data, req1_data, req0_valid, req1_valid, m_tready,
    input  req0_ready, req1_ready, m_tdata, m_tvalid, m_tlast, m_tid, busy
  );
endinterface

// File: rtl/output_stream_scheduler.sv
// Serialises words from two requesters into AXI4-Stream beats, one requester per line of
// LINE_WORDS words, with a round-robin pointer that flips after every completed line.
module output_stream_scheduler #(
  parameter int AXI_WIDTH         = 8,
  parameter int BUFFER_WIDTH      = 35,
  parameter int NUM_PACKETS       = 5,
  parameter int LAST_PACKET_WIDTH = 3,
  parameter int LINE_WORDS        = 4
) (
  input logic                       aclk,
  input logic                       areset,
  output_stream_scheduler_if.master bus
);

  localparam int PAD_W  = NUM_PACKETS * AXI_WIDTH;
  localparam int BEAT_W = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;
  localparam int WORD_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_PACKETS - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);
  localparam logic [AXI_WIDTH-1:0] FULL_MASK = {AXI_WIDTH{1'b1}};
  localparam logic [AXI_WIDTH-1:0] LAST_MASK = FULL_MASK >> (AXI_WIDTH - LAST_PACKET_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    sel_q, sel_d;
  logic                    prio_q, prio_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [PAD_W-1:0]        shift_q, shift_d;
  logic                    tvalid_q, tvalid_d;
  logic [AXI_WIDTH-1:0]    tdata_q, tdata_d;
  logic                    tlast_q, tlast_d;
  logic                    tid_q, tid_d;
  logic                    busy_q, busy_d;

  logic                    sel_valid;
  logic [BUFFER_WIDTH-1:0] sel_data;
  logic                    beat_fire;

  // The low beat of the shift register, with unused high bits cleared on the final beat.
  function automatic logic [AXI_WIDTH-1:0] beat_slice(input logic [PAD_W-1:0] sh,
                                                      input logic final_beat);
    return sh[AXI_WIDTH-1:0] & (final_beat ? LAST_MASK : FULL_MASK);
  endfunction

  assign sel_valid      = sel_q ? bus.req1_valid : bus.req0_valid;
  assign sel_data       = sel_q ? bus.req1_data : bus.req0_data;
  assign beat_fire      = tvalid_q && bus.m_tready;
  assign bus.req0_ready = (state_q == ST_LOAD) && !sel_q;
  assign bus.req1_ready = (state_q == ST_LOAD) && sel_q;
  assign bus.m_tdata    = tdata_q;
  assign bus.m_tvalid   = tvalid_q;
  assign bus.m_tlast    = tlast_q;
  assign bus.m_tid      = tid_q;
  assign bus.busy       = busy_q;

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    prio_d   = prio_q;
    beat_d   = beat_q;
    word_d   = word_q;
    shift_d  = shift_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tid_d    = tid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          sel_d   = (prio_q ? bus.req1_valid : bus.req0_valid) ? prio_q : ~prio_q;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // The line stays locked to sel until its owner presents the next word.
        if (sel_valid) begin
          shift_d  = PAD_W'(sel_data);
          beat_d   = {BEAT_W{1'b0}};
          tvalid_d = 1'b1;
          tdata_d  = beat_slice(shift_d, NUM_PACKETS == 1);
          tlast_d  = (NUM_PACKETS == 1) && (word_q == LAST_WORD);
          tid_d    = sel_q;
          state_d  = ST_SEND;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_SEND: begin
        if (beat_fire && (beat_q == LAST_BEAT)) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          beat_d   = {BEAT_W{1'b0}};
          if (word_q == LAST_WORD) begin
            word_d  = {WORD_W{1'b0}};
            prio_d  = ~sel_q;
            state_d = ST_IDLE;
          end else begin
            word_d  = word_q + WORD_W'(1);
            state_d = ST_LOAD;
          end
        end else if (beat_fire) begin
          shift_d = shift_q >> AXI_WIDTH;
          beat_d  = beat_q + BEAT_W'(1);
          tdata_d = beat_slice(shift_d, beat_d == LAST_BEAT);
          tlast_d = (beat_d == LAST_BEAT) && (word_q == LAST_WORD);
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset discards any partially sent line.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      prio_q   <= 1'b0;
      beat_q   <= {BEAT_W{1'b0}};
      word_q   <= {WORD_W{1'b0}};
      shift_q  <= {PAD_W{1'b0}};
      tvalid_q <= 1'b0;
      tdata_q  <= {AXI_WIDTH{1'b0}};
      tlast_q  <= 1'b0;
      tid_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      prio_q   <= prio_d;
      beat_q   <= beat_d;
      word_q   <= word_d;
      shift_q  <= shift_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tid_q    <= tid_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_output_stream_scheduler.sv
// Directed bench: one scheduler built with LINE_WORDS=1 and one with LINE_WORDS=4,
// checked beat by beat against hand-computed streams.
module tb_output_stream_scheduler;

  logic aclk;
  logic areset;
  int   n_vec;
  int   n_miss;

  output_stream_scheduler_if #(.AXI_WIDTH(8), .BUFFER_WIDTH(35)) i1 ();
  output_stream_scheduler_if #(.AXI_WIDTH(8), .BUFFER_WIDTH(35)) i4 ();

  output_stream_scheduler #(.LINE_WORDS(1)) dut1 (.aclk(aclk), .areset(areset), .bus(i1));
  output_stream_scheduler #(.LINE_WORDS(4)) dut4 (.aclk(aclk), .areset(areset), .bus(i4));

  logic [9:0] q1[$];
  logic [9:0] q4[$];
  int   lines1;
  int   busy_gap;
  int   r1_ready_cnt;
  logic mon4;

  logic [34:0] w_ab [4] = '{{3'b000, 32'hDEADBEEF}, {3'b001, 32'hCAFEB0BA},
                            {3'b010, 32'h12345678}, {3'b111, 32'h00A5FF00}};
  logic [7:0]  exp_ab [20] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00,
                               8'hBA, 8'hB0, 8'hFE, 8'hCA, 8'h01,
                               8'h78, 8'h56, 8'h34, 8'h12, 8'h02,
                               8'h00, 8'hFF, 8'hA5, 8'h00, 8'h07};
  logic [34:0] w_d [4] = '{{3'b101, 32'h04030201}, {3'b011, 32'h14131211},
                           {3'b110, 32'h24232221}, {3'b001, 32'h34333231}};

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Beat capture and side observations, sampled mid-cycle.
  always @(negedge aclk) begin
    if (i1.m_tvalid && i1.m_tready) begin
      q1.push_back({i1.m_tid, i1.m_tlast, i1.m_tdata});
      if (i1.m_tlast) lines1++;
    end
    if (lines1 == 1 && !i1.busy) busy_gap++;
    if (i4.m_tvalid && i4.m_tready) q4.push_back({i4.m_tid, i4.m_tlast, i4.m_tdata});
    if (mon4 && i4.req1_ready) r1_ready_cnt++;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic offer1(input bit r, input logic [34:0] w);
    int t;
    t = 0;
    if (r) begin i1.req1_data = w; i1.req1_valid = 1'b1; end
    else begin i1.req0_data = w; i1.req0_valid = 1'b1; end
    while (!(r ? i1.req1_ready : i1.req0_ready) && t < 400) begin step(); t++; end
    step();
    if (r) i1.req1_valid = 1'b0; else i1.req0_valid = 1'b0;
    check_val(r ? "req1 accept" : "req0 accept", 64'(t < 400), 64'd1);
  endtask

  task automatic offer4(input logic [34:0] w);
    int t;
    t = 0;
    i4.req0_data  = w;
    i4.req0_valid = 1'b1;
    while (!i4.req0_ready && t < 400) begin step(); t++; end
    step();
    i4.req0_valid = 1'b0;
    check_val("d4 req0 accept", 64'(t < 400), 64'd1);
  endtask

  task automatic wait_q1(input int n);
    int t;
    t = 0;
    while (q1.size() < n && t < 400) begin step(); t++; end
    check_val("q1 beats", 64'(q1.size()), 64'(n));
  endtask

  task automatic wait_beat1(input logic [7:0] d);
    int t;
    t = 0;
    while (!(i1.m_tvalid && i1.m_tdata == d) && t < 200) begin step(); t++; end
    check_val("wait beat", 64'(t < 200), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t;
    logic [9:0]  e;
    logic [34:0] tmp;
    n_vec = 0; n_miss = 0; lines1 = 0; busy_gap = 0; r1_ready_cnt = 0; mon4 = 1'b0;
    areset = 1'b0;
    i1.req0_data = '0; i1.req1_data = '0; i1.req0_valid = 1'b0; i1.req1_valid = 1'b0;
    i1.m_tready = 1'b1;
    i4.req0_data = '0; i4.req1_data = '0; i4.req0_valid = 1'b0; i4.req1_valid = 1'b0;
    i4.m_tready = 1'b1;
    #1;
    check_val("rst tvalid", 64'(i1.m_tvalid), 64'd0);
    check_val("rst busy", 64'(i1.busy), 64'd0);
    check_val("rst ready", 64'({i1.req0_ready, i1.req1_ready}), 64'd0);
    repeat (3) step();
    areset = 1'b1;
    step();
    check_val("idle busy", 64'(i1.busy), 64'd0);

    // Four lines with both requesters contending: expect 0,1,0,1.
    base = q1.size();
    fork
      begin offer1(1'b0, w_ab[0]); offer1(1'b0, w_ab[2]); end
      begin offer1(1'b1, w_ab[1]); offer1(1'b1, w_ab[3]); end
    join
    wait_q1(base + 20);
    for (int k = 0; k < 20; k++) begin
      e = q1[base + k];
      check_val($sformatf("rr data %0d", k), 64'(e[7:0]), 64'(exp_ab[k]));
      check_val($sformatf("rr last %0d", k), 64'(e[8]), 64'(k % 5 == 4));
      check_val($sformatf("rr tid %0d", k), 64'(e[9]), 64'((k / 5) % 2));
    end
    check_val("busy gap", 64'(busy_gap), 64'd1);

    // Four-word line locked to req0 while req1 stays valid.
    mon4 = 1'b1;
    i4.req1_data  = {3'b010, 32'h55555555};
    i4.req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      offer4(w_d[k]);
      repeat (3) step();
    end
    t = 0;
    while (q4.size() < 20 && t < 400) begin step(); t++; end
    i4.req1_valid = 1'b0;
    mon4 = 1'b0;
    repeat (6) step();
    check_val("d4 beats", 64'(q4.size()), 64'd20);
    for (int k = 0; k < 20 && k < q4.size(); k++) begin
      e   = q4[k];
      tmp = w_d[k / 5] >> (8 * (k % 5));
      check_val($sformatf("d4 data %0d", k), 64'(e[7:0]), 64'(tmp[7:0]));
      check_val($sformatf("d4 last %0d", k), 64'(e[8]), 64'(k == 19));
      check_val($sformatf("d4 tid %0d", k), 64'(e[9]), 64'd0);
    end
    check_val("d4 req1_ready", 64'(r1_ready_cnt), 64'd0);

    // Backpressure on the third beat.
    base = q1.size();
    fork
      offer1(1'b0, w_ab[0]);
      begin
        wait_beat1(8'hBE);
        step();
        i1.m_tready = 1'b0;
        check_val("bp data a", 64'(i1.m_tdata), 64'hAD);
        step();
        check_val("bp data b", 64'(i1.m_tdata), 64'hAD);
        check_val("bp valid b", 64'(i1.m_tvalid), 64'd1);
        step();
        check_val("bp data c", 64'(i1.m_tdata), 64'hAD);
        check_val("bp valid c", 64'(i1.m_tvalid), 64'd1);
        i1.m_tready = 1'b1;
      end
    join
    wait_q1(base + 5);
    for (int k = 0; k < 5; k++) begin
      e = q1[base + k];
      check_val($sformatf("bp beat %0d", k), 64'(e), 64'({2'b00, exp_ab[k]} | ((k == 4) ? 10'h100 : 10'h000)));
    end

    // Reset in the middle of a line, then restart with both requesters valid.
    fork
      offer1(1'b0, w_ab[0]);
      wait_beat1(8'hDE);
    join
    areset = 1'b0;
    #1;
    check_val("mid rst tvalid", 64'(i1.m_tvalid), 64'd0);
    check_val("mid rst tdata", 64'(i1.m_tdata), 64'd0);
    check_val("mid rst tlast", 64'(i1.m_tlast), 64'd0);
    check_val("mid rst tid", 64'(i1.m_tid), 64'd0);
    check_val("mid rst busy", 64'(i1.busy), 64'd0);
    check_val("mid rst ready", 64'({i1.req0_ready, i1.req1_ready}), 64'd0);
    step();
    step();
    areset = 1'b1;
    base = q1.size();
    fork
      offer1(1'b0, w_ab[0]);
      offer1(1'b1, w_ab[1]);
    join
    wait_q1(base + 10);
    for (int k = 0; k < 10; k++) begin
      e = q1[base + k];
      check_val($sformatf("post rst data %0d", k), 64'(e[7:0]), 64'(exp_ab[k]));
      check_val($sformatf("post rst tid %0d", k), 64'(e[9]), 64'(k / 5));
    end
    repeat (4) step();
    check_val("post rst idle", 64'(i1.busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
